// File: rtl/viterbi_decoder_if.sv
// Symbol stream in, decoded bit stream plus channel-quality metric out.
interface viterbi_decoder_if #(
  parameter int PM_WIDTH = 6
);
  logic                sym_in;
  logic                sym_valid;
  logic                out_bit;
  logic                out_valid;
  logic [PM_WIDTH-1:0] pm_min;

  modport master (output sym_in, sym_valid, input out_bit, out_valid, pm_min);
  modport slave  (input sym_in, sym_valid, output out_bit, out_valid, pm_min);
endinterface

// File: rtl/viterbi_decoder.sv
// Hard-decision Viterbi decoder, rate 1/2, K=3, 4 states.
// State index = {s1,s2}; s1 is the most recent information bit.
// Register-exchange survivors; metrics are renormalised every step so the
// best state always sits at 0 and saturation only ever hits losing paths.
module viterbi_decoder #(
  parameter int TB_DEPTH = 16,
  parameter int PM_WIDTH = 6
) (
  input  logic              clock,
  input  logic              reset,
  input  logic              clear,
  viterbi_decoder_if.slave  bus
);
  localparam int S  = 4;
  localparam int CW = $clog2(TB_DEPTH + 1);
  localparam logic [PM_WIDTH-1:0] PM_MAX  = '1;
  localparam logic [PM_WIDTH-1:0] PM_HALF = PM_WIDTH'(1) << (PM_WIDTH - 1);
  // Encoder starts in state 00, so every other state begins heavily penalised.
  localparam logic [S-1:0][PM_WIDTH-1:0] PM_INIT = {PM_HALF, PM_HALF, PM_HALF, {PM_WIDTH{1'b0}}};

  logic                          phase;
  logic                          r1;
  logic [S-1:0][PM_WIDTH-1:0]    pm;
  logic [S-1:0][TB_DEPTH-1:0]    path;
  logic [CW-1:0]                 step_cnt;
  logic                          step_done;

  logic [S-1:0][PM_WIDTH-1:0]    cand;
  logic [S-1:0][TB_DEPTH-1:0]    path_next;
  logic [PM_WIDTH-1:0]           cand_min;
  logic [1:0]                    best;

  function automatic logic [1:0] bmet(logic a1, logic a0, logic e1, logic e0);
    return {1'b0, a1 ^ e1} + {1'b0, a0 ^ e0};
  endfunction

  function automatic logic [PM_WIDTH-1:0] sat_add(logic [PM_WIDTH-1:0] a, logic [1:0] b);
    logic [PM_WIDTH:0] s;
    s = {1'b0, a} + {{(PM_WIDTH-1){1'b0}}, b};
    return s[PM_WIDTH] ? PM_MAX : s[PM_WIDTH-1:0];
  endfunction

  // One ACS unit per next state {u,p}; predecessors are {p,0} and {p,1}.
  for (genvar ns = 0; ns < S; ns++) begin : g_acs
    localparam int   U  = ns / 2;
    localparam int   P  = ns % 2;
    localparam int   PA = 2 * P;
    localparam int   PB = 2 * P + 1;
    localparam logic EU = 1'(U ^ P);
    logic [PM_WIDTH-1:0] c_a, c_b, win_pm;
    logic [TB_DEPTH-1:0] win_path;

    // Compare-select; ties go to the predecessor with s2=0.
    always_comb begin
      c_a = sat_add(pm[PA], bmet(r1, bus.sym_in, EU, EU));
      c_b = sat_add(pm[PB], bmet(r1, bus.sym_in, ~EU, EU));
      if (c_a <= c_b) begin
        win_pm   = c_a;
        win_path = {path[PA][TB_DEPTH-2:0], 1'(U)};
      end else begin
        win_pm   = c_b;
        win_path = {path[PB][TB_DEPTH-2:0], 1'(U)};
      end
    end

    assign cand[ns]      = win_pm;
    assign path_next[ns] = win_path;
  end

  // Smallest new candidate, used for normalisation and reported as pm_min.
  always_comb begin
    cand_min = cand[0];
    for (int i = 1; i < S; i++)
      if (cand[i] < cand_min) cand_min = cand[i];
  end

  // Lowest-index state whose registered metric is 0.
  always_comb begin
    best = 2'd0;
    for (int i = S - 1; i >= 0; i--)
      if (pm[i] == '0) best = 2'(i);
  end

  // Symbol pairing, trellis step, and output one cycle after a qualifying step.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      phase <= 1'b0; r1 <= 1'b0; pm <= PM_INIT; path <= '0;
      step_cnt <= '0; step_done <= 1'b0;
      bus.out_bit <= 1'b0; bus.out_valid <= 1'b0; bus.pm_min <= '0;
    end else if (clear) begin
      phase <= 1'b0; r1 <= 1'b0; pm <= PM_INIT; path <= '0;
      step_cnt <= '0; step_done <= 1'b0;
      bus.out_bit <= 1'b0; bus.out_valid <= 1'b0; bus.pm_min <= '0;
    end else begin
      step_done     <= 1'b0;
      bus.out_valid <= 1'b0;
      if (bus.sym_valid) begin
        if (!phase) begin
          r1    <= bus.sym_in;
          phase <= 1'b1;
        end else begin
          phase     <= 1'b0;
          for (int i = 0; i < S; i++) pm[i] <= cand[i] - cand_min;
          path      <= path_next;
          bus.pm_min <= cand_min;
          step_done <= 1'b1;
          if (step_cnt != CW'(TB_DEPTH)) step_cnt <= step_cnt + CW'(1);
        end
      end
      if (step_done && step_cnt == CW'(TB_DEPTH)) begin
        bus.out_valid <= 1'b1;
        bus.out_bit   <= path[best][TB_DEPTH-1];
      end
    end
  end
endmodule

// File: tb/tb_viterbi_decoder.sv
// Directed bench for viterbi_decoder: table of encoded streams plus
// hand-written reset/clear corner sequences.
module tb_viterbi_decoder;
  localparam int D = 16;
  localparam int W = 6;

  logic clock = 1'b0;
  logic reset = 1'b1;
  logic clear = 1'b0;

  viterbi_decoder_if #(.PM_WIDTH(W)) bus ();

  viterbi_decoder #(.TB_DEPTH(D), .PM_WIDTH(W)) dut (
    .clock(clock), .reset(reset), .clear(clear), .bus(bus)
  );

  always #5 clock = ~clock;

  typedef struct {
    string       name;
    logic [79:0] syms;      // pair p at [2p+1:2p], [2p+1] sent first
    int          npairs;
    int          max_gap;
    bit          chk_bits;
    logic [24:0] exp_bits;  // i-th decoded bit at [i]
    int          exp_pulses;
    int          pm_lo;
    int          pm_hi;
  } vec_t;

  vec_t vecs[5];

  int compared = 0;
  int mismatched = 0;

  // bench-side pairing model
  bit          tb_phase;
  int          tb_steps;
  bit          prev_step;
  int          pulses;
  int          first_pair;
  int          pm_max;
  logic [63:0] got_bits;

  task automatic check(string nm, int act, int exp);
    compared++;
    if (act != exp) begin
      mismatched++;
      $display("FAIL %s: got %0d expected %0d", nm, act, exp);
    end
  endtask

  task automatic mon_reset();
    pulses = 0; first_pair = -1; pm_max = 0; got_bits = '0;
  endtask

  task automatic tick();
    bit stp, clr;
    stp = bus.sym_valid && tb_phase && !clear && !reset;
    clr = clear || reset;
    @(posedge clock); #1;
    check("out_valid", int'(bus.out_valid), int'(prev_step && !clr && tb_steps >= D));
    if (bus.out_valid) begin
      if (pulses < 64) got_bits[pulses] = bus.out_bit;
      if (pulses == 0) first_pair = tb_steps;
      pulses++;
    end
    if (int'(bus.pm_min) > pm_max) pm_max = int'(bus.pm_min);
    if (clr) begin
      tb_phase = 1'b0; tb_steps = 0;
    end else if (bus.sym_valid) begin
      if (tb_phase) tb_steps++;
      tb_phase = !tb_phase;
    end
    prev_step = stp;
  endtask

  task automatic send_sym(logic b, int max_gap);
    bus.sym_valid = 1'b1;
    bus.sym_in    = b;
    tick();
    bus.sym_valid = 1'b0;
    bus.sym_in    = 1'b0;
    if (max_gap > 0) repeat ($urandom_range(0, max_gap)) tick();
  endtask

  task automatic run_vec(vec_t v, bit do_clear);
    mon_reset();
    if (do_clear) begin
      clear = 1'b1; tick(); clear = 1'b0;
    end
    for (int p = 0; p < v.npairs; p++) begin
      send_sym(v.syms[2*p+1], v.max_gap);
      send_sym(v.syms[2*p], v.max_gap);
    end
    repeat (3) tick();
    check({v.name, " pulses"}, pulses, v.exp_pulses);
    check({v.name, " first_pair"}, first_pair, D);
    if (v.chk_bits)
      for (int i = 0; i < v.exp_pulses; i++)
        check($sformatf("%s bit%0d", v.name, i), int'(got_bits[i]), int'(v.exp_bits[i]));
    check({v.name, " pm_lo"}, int'(pm_max >= v.pm_lo), 1);
    check({v.name, " pm_hi"}, int'(pm_max <= v.pm_hi), 1);
  endtask

  vec_t zeros20;

  initial begin
    vecs[0] = '{"zeros",   80'h0, 40, 0, 1'b1, 25'h0, 25, 0, 0};
    vecs[1] = '{"impulse", 80'h0, 20, 0, 1'b1, 25'h1, 5, 0, 0};
    vecs[1].syms[5:0] = 6'b101111;                 // 11 11 10
    vecs[2] = '{"err1011", 80'h0, 20, 0, 1'b1, 25'h0D, 5, 1, 1};
    vecs[2].syms[11:0] = 12'b100100111111;         // 11 11 11(err) 00 01 10
    vecs[3] = vecs[2];
    vecs[3].name = "gaps1011";
    vecs[3].max_gap = 5;
    vecs[4] = '{"ones", '1, 40, 0, 1'b0, 25'h0, 25, 0, 2};
    zeros20 = '{"restart", 80'h0, 20, 0, 1'b1, 25'h0, 5, 0, 0};

    bus.sym_in = 1'b0; bus.sym_valid = 1'b0;
    tb_phase = 1'b0; tb_steps = 0; prev_step = 1'b0;
    mon_reset();

    // reset state
    repeat (2) @(posedge clock);
    #1;
    check("rst out_bit", int'(bus.out_bit), 0);
    check("rst out_valid", int'(bus.out_valid), 0);
    check("rst pm_min", int'(bus.pm_min), 0);
    reset = 1'b0;
    tick();

    foreach (vecs[i]) run_vec(vecs[i], 1'b1);

    // reset mid-pair after 10 pairs of a nonzero stream
    mon_reset();
    clear = 1'b1; tick(); clear = 1'b0;
    for (int p = 0; p < 10; p++) begin
      send_sym(vecs[2].syms[2*p+1], 0);
      send_sym(vecs[2].syms[2*p], 0);
    end
    send_sym(1'b1, 0);
    reset = 1'b1;
    #1;
    check("midrst out_bit", int'(bus.out_bit), 0);
    check("midrst out_valid", int'(bus.out_valid), 0);
    check("midrst pm_min", int'(bus.pm_min), 0);
    tick();
    reset = 1'b0;
    tick();
    zeros20.name = "after_reset";
    run_vec(zeros20, 1'b0);

    // clear coinciding with a valid symbol while a pair is half received
    mon_reset();
    send_sym(1'b1, 0); send_sym(1'b1, 0); send_sym(1'b1, 0);
    clear = 1'b1; bus.sym_valid = 1'b1; bus.sym_in = 1'b1;
    tick();
    clear = 1'b0; bus.sym_valid = 1'b0; bus.sym_in = 1'b0;
    check("clr out_valid", int'(bus.out_valid), 0);
    check("clr pm_min", int'(bus.pm_min), 0);
    zeros20.name = "after_clear";
    run_vec(zeros20, 1'b0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end
endmodule
